// File: rtl/axi_burst_mem_slave.sv
// AXI4 slave with an internal word-addressed memory. It supports FIXED/INCR/WRAP bursts,
// byte strobes, a programmable read latency and SLVERR for out-of-range beats.
module axi_burst_mem_slave #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);
  localparam int BPB = DATA_W / 8;
  localparam int OFF = (BPB > 1) ? $clog2(BPB) : 0;
  localparam int IW  = ADDR_W - OFF;
  localparam int MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

  // WRAP keeps the high index bits and increments only inside the (len+1)-word block.
  function automatic logic [IW-1:0] nextIdx(input logic [IW-1:0] idx, input logic [7:0] len,
                                            input logic [1:0] burst);
    logic [IW-1:0] mask;
    logic [IW-1:0] inc;
    mask = IW'(len);
    inc  = idx + IW'(1);
    case (burst)
      2'b00:   nextIdx = idx;
      2'b10:   nextIdx = (idx & ~mask) | (inc & mask);
      default: nextIdx = inc;
    endcase
  endfunction

  function automatic logic isIllegal(input logic [1:0] burst, input logic [7:0] len);
    isIllegal = (burst == 2'b11) ||
                ((burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  function automatic logic [1:0] effBurst(input logic [1:0] burst, input logic [7:0] len);
    effBurst = isIllegal(burst, len) ? 2'b01 : burst;
  endfunction

  function automatic logic inRange(input logic [IW-1:0] idx);
    inRange = (idx < IW'(DEPTH));
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_live;

  wstate_t       r_wState, w_wNext;
  logic [IW-1:0] r_awIdx;
  logic [7:0]    r_awLen, r_wBeat;
  logic [1:0]    r_awBurst;
  logic          r_wErr;
  logic          w_awFire, w_wFire, w_wLastBeat, w_wInRange;

  rstate_t       r_rState, w_rNext;
  logic [IW-1:0] r_arIdx, w_fIdx;
  logic [7:0]    r_arLen, r_rBeat;
  logic [1:0]    r_arBurst;
  logic          r_arErr, r_rlast;
  logic [CW-1:0] r_latCnt;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]    r_rresp;
  logic          w_arFire, w_rFire, w_waitDone, w_fetch, w_fLast, w_fErr;

  if (OFF > 0) begin : g_offset
    logic w_unused;
    assign w_unused = ^{awaddr[OFF-1:0], araddr[OFF-1:0]};
  end

  assign w_awFire    = awvalid & awready;
  assign w_wFire     = wvalid & wready;
  assign w_wLastBeat = (r_wBeat == r_awLen);
  assign w_wInRange  = inRange(r_awIdx);
  assign w_arFire    = arvalid & arready;
  assign w_rFire     = rvalid & rready;
  assign w_waitDone  = (r_latCnt == CW'(RD_LAT - 2));

  // r_live holds both address-ready outputs low until the first clock after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_live <= 1'b0;
    else          r_live <= 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_wState <= W_IDLE;
    else          r_wState <= w_wNext;
  end

  always_comb begin
    w_wNext = r_wState;
    case (r_wState)
      W_IDLE:  if (w_awFire) w_wNext = W_DATA;
      W_DATA:  if (w_wFire && w_wLastBeat) w_wNext = W_RESP;
      W_RESP:  if (bready) w_wNext = W_IDLE;
      default: w_wNext = W_IDLE;
    endcase
  end

  always_comb begin
    awready = r_live && (r_wState == W_IDLE);
    wready  = (r_wState == W_DATA);
    bvalid  = (r_wState == W_RESP);
    bresp   = ((r_wState == W_RESP) && r_wErr) ? 2'b10 : 2'b00;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_awIdx   <= '0;
      r_awLen   <= '0;
      r_awBurst <= '0;
      r_wBeat   <= '0;
      r_wErr    <= 1'b0;
    end else if (w_awFire) begin
      r_awIdx   <= awaddr[ADDR_W-1:OFF];
      r_awLen   <= awlen;
      r_awBurst <= effBurst(awburst, awlen);
      r_wBeat   <= '0;
      r_wErr    <= isIllegal(awburst, awlen);
    end else if (w_wFire) begin
      r_awIdx <= nextIdx(r_awIdx, r_awLen, r_awBurst);
      r_wBeat <= r_wBeat + 8'd1;
      r_wErr  <= r_wErr | !w_wInRange | (wlast != w_wLastBeat);
    end
  end

  always_ff @(posedge aclk) begin
    if (w_wFire && w_wInRange) begin
      for (int b = 0; b < BPB; b++) begin
        if (wstrb[b]) r_mem[r_awIdx[MW-1:0]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_rState <= R_IDLE;
    else          r_rState <= w_rNext;
  end

  always_comb begin
    w_rNext = r_rState;
    case (r_rState)
      R_IDLE:  if (w_arFire) w_rNext = (RD_LAT == 1) ? R_DATA : R_WAIT;
      R_WAIT:  if (w_waitDone) w_rNext = R_DATA;
      R_DATA:  if (w_rFire && (r_rBeat == r_arLen)) w_rNext = R_IDLE;
      default: w_rNext = R_IDLE;
    endcase
  end

  always_comb begin
    arready = r_live && (r_rState == R_IDLE);
    rvalid  = (r_rState == R_DATA);
    rdata   = r_rdata;
    rresp   = r_rresp;
    rlast   = (r_rState == R_DATA) && r_rlast;
  end

  // Each beat's data is fetched into the output register one cycle ahead of being presented.
  always_comb begin
    w_fetch = 1'b0;
    w_fIdx  = r_arIdx;
    w_fLast = (r_arLen == 8'd0);
    w_fErr  = r_arErr;
    case (r_rState)
      R_IDLE: if (w_arFire && (RD_LAT == 1)) begin
        w_fetch = 1'b1;
        w_fIdx  = araddr[ADDR_W-1:OFF];
        w_fLast = (arlen == 8'd0);
        w_fErr  = isIllegal(arburst, arlen);
      end
      R_WAIT: w_fetch = w_waitDone;
      R_DATA: if (w_rFire && (r_rBeat != r_arLen)) begin
        w_fetch = 1'b1;
        w_fIdx  = nextIdx(r_arIdx, r_arLen, r_arBurst);
        w_fLast = (8'(r_rBeat + 8'd1) == r_arLen);
      end
      default: w_fetch = 1'b0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_arIdx   <= '0;
      r_arLen   <= '0;
      r_arBurst <= '0;
      r_arErr   <= 1'b0;
      r_rBeat   <= '0;
      r_latCnt  <= '0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
      r_rlast   <= 1'b0;
    end else begin
      if (w_arFire) begin
        r_arIdx   <= araddr[ADDR_W-1:OFF];
        r_arLen   <= arlen;
        r_arBurst <= effBurst(arburst, arlen);
        r_arErr   <= isIllegal(arburst, arlen);
        r_rBeat   <= '0;
        r_latCnt  <= '0;
      end else if (r_rState == R_WAIT) begin
        r_latCnt <= r_latCnt + CW'(1);
      end
      if (w_fetch) begin
        r_rdata <= inRange(w_fIdx) ? r_mem[w_fIdx[MW-1:0]] : '0;
        r_rresp <= (!inRange(w_fIdx) || w_fErr) ? 2'b10 : 2'b00;
        r_rlast <= w_fLast;
      end
      if (w_fetch && (r_rState == R_DATA)) begin
        r_arIdx <= w_fIdx;
        r_rBeat <= r_rBeat + 8'd1;
      end
    end
  end
endmodule
